// File: rtl/rsff_access_arbiter.sv
// rsff_access_arbiter
// Shares one external set-priority RS flip-flop among NREQ requesters.
// Requests are arbitrated round-robin. Each granted operation drives a
// timed S or R pulse, then a recovery gap in which both drives are low.
// At power-up the flip-flop is cleared with an R pulse. Q is checked at the
// end of every requester pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req_s     per-requester set request (level, held until ack)
//   req_r     per-requester reset request (level, held until ack)
//   ack       one-cycle completion pulse, one bit per requester
//   q_in      Q of the controlled flip-flop
//   s_out     S drive to the flip-flop
//   r_out     R drive to the flip-flop
//   busy      high in every state except IDLE
//   grant_id  requester being serviced (0 outside PULSE/RECOVER)
//   err       sticky: Q did not reach the target by the end of a pulse
module rsff_access_arbiter #(
  parameter int NREQ           = 4,
  parameter int PULSE_W        = 2,
  parameter int RECOV_W        = 1,
  parameter bit SKIP_REDUNDANT = 1'b1,
  localparam int GW = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_s,
  input  logic [NREQ-1:0] req_r,
  output logic [NREQ-1:0] ack,
  input  logic            q_in,
  output logic            s_out,
  output logic            r_out,
  output logic            busy,
  output logic [GW-1:0]   grant_id,
  output logic            err
);

  localparam int CMAX = (PULSE_W > RECOV_W) ? PULSE_W : RECOV_W;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] RECOV_LAST = CW'(RECOV_W - 1);

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    PULSE   = 2'd1,
    RECOVER = 2'd2,
    IDLE    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [GW-1:0]   grant_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic            s_nxt, r_nxt, busy_nxt, err_nxt;
  // target: 1 = set, 0 = reset, for the operation in flight
  logic            target, target_nxt;
  // op_valid distinguishes a requester operation from the power-up clear,
  // both of which pass through RECOVER
  logic            op_valid, op_valid_nxt;

  logic [NREQ-1:0] active;
  logic            found;
  logic [GW-1:0]   win;
  logic            win_tgt;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] v);
    if (v == GW'(NREQ - 1)) return '0;
    return v + GW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [GW-1:0] v);
    logic [NREQ-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (GW'(i) == v) r[i] = 1'b1;
    return r;
  endfunction

  // Round-robin search from rr_ptr. A requester whose ack is high this cycle
  // is masked so a held request is not serviced twice.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    win     = '0;
    win_tgt = 1'b0;
    active  = (req_s | req_r) & ~ack;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && active[idx]) begin
        found   = 1'b1;
        win     = GW'(idx);
        win_tgt = req_s[idx];
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    rr_ptr_nxt   = rr_ptr;
    grant_nxt    = grant_id;
    ack_nxt      = '0;
    s_nxt        = 1'b0;
    r_nxt        = 1'b0;
    busy_nxt     = 1'b1;
    err_nxt      = err;
    target_nxt   = target;
    op_valid_nxt = op_valid;

    case (state)
      INIT: begin
        r_nxt = 1'b1;
        if (cnt == PULSE_LAST) begin
          state_nxt = RECOVER;
          cnt_nxt   = '0;
          r_nxt     = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      PULSE: begin
        s_nxt = target;
        r_nxt = ~target;
        if (cnt == PULSE_LAST) begin
          if (q_in != target) err_nxt = 1'b1;
          state_nxt = RECOVER;
          cnt_nxt   = '0;
          s_nxt     = 1'b0;
          r_nxt     = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      RECOVER: begin
        if (cnt == RECOV_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          grant_nxt = '0;
          if (op_valid) begin
            ack_nxt      = onehot(grant_id);
            rr_ptr_nxt   = wrap_inc(grant_id);
            op_valid_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      IDLE: begin
        busy_nxt  = 1'b0;
        grant_nxt = '0;
        if (found) begin
          if (SKIP_REDUNDANT && (q_in == win_tgt)) begin
            // flip-flop already holds the target: acknowledge without a pulse
            ack_nxt    = onehot(win);
            rr_ptr_nxt = wrap_inc(win);
          end else begin
            state_nxt    = PULSE;
            cnt_nxt      = '0;
            grant_nxt    = win;
            busy_nxt     = 1'b1;
            target_nxt   = win_tgt;
            op_valid_nxt = 1'b1;
            s_nxt        = win_tgt;
            r_nxt        = ~win_tgt;
          end
        end
      end

      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
        r_nxt     = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset aborts any operation and restarts the
  // power-up clear with R already asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      cnt      <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      ack      <= '0;
      s_out    <= 1'b0;
      r_out    <= 1'b1;
      busy     <= 1'b1;
      err      <= 1'b0;
      target   <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
      ack      <= ack_nxt;
      s_out    <= s_nxt;
      r_out    <= r_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
      target   <= target_nxt;
      op_valid <= op_valid_nxt;
    end
  end

endmodule

// File: doc/rsff_access_arbiter.md
Name: rsff_access_arbiter

Overview:
- Shares one external set-priority RS flip-flop among NREQ requesters, each of which may request a set or a reset.
- Arbitrates round-robin and drives the flip-flop's S/R inputs as timed pulses.
- Enforces a recovery gap between operations, so S and R are never high together.
- Sequences the power-up clear and checks the flip-flop's Q after every pulse.

Parameters:
NREQ, 4, number of requesters (2..16)
PULSE_W, 2, cycles S_OUT/R_OUT held high per operation (>=1)
RECOV_W, 1, cycles with S_OUT=R_OUT=0 after each pulse (>=1)
SKIP_REDUNDANT, 1, 1 = acknowledge without pulsing when Q_IN already equals the target

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ_S  input  NREQ  per-requester set request, level, held until ACK
REQ_R  input  NREQ  per-requester reset request, level, held until ACK
ACK  output  NREQ  one-cycle completion pulse, per requester
Q_IN  input  1  Q of the controlled flip-flop
S_OUT  output  1  S drive to flip-flop
R_OUT  output  1  R drive to flip-flop
BUSY  output  1  high in every state except IDLE
GRANT_ID  output  max(1,clog2(NREQ))  index of requester being serviced; 0 when not in PULSE/RECOVER
ERR  output  1  sticky: Q_IN mismatched target at end of a pulse

Behaviour:
- All outputs are registered. States: INIT, PULSE, RECOVER, IDLE.
- Reset asserted (async): state=INIT, R_OUT=1, S_OUT=0, ACK=0, BUSY=1, GRANT_ID=0, ERR=0, rr pointer=0. Any operation in flight is aborted and gets no ACK.
- INIT after release:
  - R_OUT stays 1 for PULSE_W cycles, then RECOVER for RECOV_W cycles, then IDLE.
  - No ACK is produced.
  - Not checked for ERR.
- IDLE, request detection:
  - Requester i is "active" if REQ_S[i]|REQ_R[i] and ACK[i]=0 in that cycle. A requester still holding REQ during its own ACK cycle is masked.
  - If no requester is active, stay in IDLE.
- IDLE, arbitration:
  - Winner = first active index searching from the rr pointer upward, wrapping at NREQ-1 -> 0.
  - Target = set if REQ_S[i]=1, else reset. Both S and R requested = set (set priority).
- IDLE, redundant request (SKIP_REDUNDANT=1 and Q_IN already equals target):
  - ACK[i]=1 on the next edge.
  - Stay in IDLE; no pulse; pointer becomes i+1 mod NREQ.
- IDLE, normal grant:
  - Next edge: state=PULSE, GRANT_ID=i.
  - Drive S_OUT=1 for a set target, else R_OUT=1.
  - Pulse is held for exactly PULSE_W cycles.
- PULSE end (last cycle): sample Q_IN. If Q_IN != target, set ERR (cleared only by reset).
- RECOVER:
  - S_OUT=R_OUT=0 for exactly RECOV_W cycles.
  - On the leaving edge: ACK[GRANT_ID]=1 for one cycle, state=IDLE, pointer=GRANT_ID+1 mod NREQ.
- In the ACK cycle, arbitration among the other requesters proceeds normally, so back-to-back operations are possible.
- Latency, request sampled to ACK high:
  - Normal path: PULSE_W+RECOV_W+1 cycles.
  - Redundant path: 1 cycle.
- Invariants (checked by the bench):
  - S_OUT&R_OUT never 1.
  - At most one ACK bit high.
  - Gap between consecutive pulses is >= RECOV_W cycles.
- REQ inputs changing while their requester is granted do not affect the operation in flight.

Test Plan:
- Reset then idle: RST_N low 3 cycles, release -> R_OUT=1 during reset and 2 cycles after, 0 for 1 cycle, then BUSY=0; ACK=0 throughout; ERR=0.
- Single set: REQ_S[1]=1 with Q_IN=0, Q_IN follows S_OUT one cycle later -> S_OUT high 2 cycles, low 1 cycle, ACK=4'b0010 on the 4th cycle after sampling; GRANT_ID=1 while busy; ERR=0.
- Redundant skip: Q_IN=1, REQ_S[2]=1 -> ACK=4'b0100 one cycle later; S_OUT/R_OUT stay 0; BUSY stays 0.
- Round-robin and set priority: REQ_S[0], REQ_R[3], and REQ_S[2]+REQ_R[2] all held from one cycle -> grants in order 0,2,3. Requester 2 is issued a set; no S/R overlap; each pulse separated by >=1 idle-drive cycle.
- Fault: REQ_R[0] with Q_IN held 1 -> R_OUT pulses 2 cycles, ERR=1 after the pulse and stays 1; ACK[0] is still issued.
- Reset mid-pulse: assert RST_N during PULSE of a set -> S_OUT=0 and R_OUT=1 immediately; no ACK for that requester; re-request after INIT completes and is serviced normally.
